// File: rtl/dct_transpose_ctrl_if.sv
// Stream bundle for the DCT transpose scheduler.
// Row-pass samples enter on i_*, column-pass samples leave on o_*.
interface dct_transpose_ctrl_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  i_valid;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  o_ready;
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  i_ready;
  logic                  o_sof;
  logic                  o_eol;
  logic                  o_busy;

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data,
    output o_sof, o_eol, o_busy
  );

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data,
    input  o_sof, o_eol, o_busy
  );
endinterface

// File: rtl/dct_transpose_ctrl.sv
// Ping-pong transpose buffer between the row and column DCT passes.
// Blocks are written row-major and replayed column-major.
module dct_transpose_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  dct_transpose_ctrl_if.slave bus
);
  localparam int CW    = $clog2(N);
  localparam int BW    = 2 * CW;
  localparam int DEPTH = 2 << BW;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    DRAINING
  } bank_t;

  bank_t st_q [2];
  bank_t st_d [2];

  logic          wsel_q, wsel_d;
  logic          rsel_q, rsel_d;
  logic [CW-1:0] wrow_q, wrow_d;
  logic [CW-1:0] wcol_q, wcol_d;
  logic [CW-1:0] rrow_q, rrow_d;
  logic [CW-1:0] rcol_q, rcol_d;
  logic          rdy_q, rdy_d;
  logic          vld_q, vld_d;
  logic          sof_q, sof_d;
  logic          eol_q, eol_d;

  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic        wr;
  logic        load;
  logic        wlast;
  logic        rlast;
  logic [BW:0] waddr;
  logic [BW:0] raddr;

  assign wr    = bus.i_valid && rdy_q;
  assign wlast = (wrow_q == CW'(N - 1)) &&
                 (wcol_q == CW'(N - 1));
  assign rlast = (rrow_q == CW'(N - 1)) &&
                 (rcol_q == CW'(N - 1));
  assign waddr = {wsel_q, wrow_q, wcol_q};
  // rrow is the inner counter, so reads walk down a column
  assign raddr = {rsel_q, rrow_q, rcol_q};
  assign load  = (!vld_q || bus.i_ready) &&
                 ((st_q[rsel_q] == FULL) ||
                  (st_q[rsel_q] == DRAINING));

  always_comb begin
    st_d[0] = st_q[0];
    st_d[1] = st_q[1];
    wsel_d  = wsel_q;
    rsel_d  = rsel_q;
    wrow_d  = wrow_q;
    wcol_d  = wcol_q;
    rrow_d  = rrow_q;
    rcol_d  = rcol_q;
    vld_d   = vld_q;
    sof_d   = sof_q;
    eol_d   = eol_q;
    dat_d   = dat_q;
    if (wr) begin
      wcol_d = wcol_q + CW'(1);
      if (wcol_q == CW'(N - 1))
        wrow_d = wrow_q + CW'(1);
      st_d[wsel_q] = wlast ? FULL : FILLING;
      if (wlast)
        wsel_d = ~wsel_q;
    end
    // bank is freed once its last sample sits in the output reg
    if (load) begin
      rrow_d = rrow_q + CW'(1);
      if (rrow_q == CW'(N - 1))
        rcol_d = rcol_q + CW'(1);
      st_d[rsel_q] = rlast ? EMPTY : DRAINING;
      if (rlast)
        rsel_d = ~rsel_q;
      vld_d = 1'b1;
      sof_d = (rrow_q == '0) && (rcol_q == '0);
      eol_d = (rrow_q == CW'(N - 1));
      dat_d = mem[raddr];
    end else if (bus.i_ready) begin
      vld_d = 1'b0;
      sof_d = 1'b0;
      eol_d = 1'b0;
    end
    rdy_d = (st_d[wsel_d] == EMPTY) ||
            (st_d[wsel_d] == FILLING);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      st_q[0] <= EMPTY;
      st_q[1] <= EMPTY;
      wsel_q  <= 1'b0;
      rsel_q  <= 1'b0;
      wrow_q  <= '0;
      wcol_q  <= '0;
      rrow_q  <= '0;
      rcol_q  <= '0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      st_q[0] <= st_d[0];
      st_q[1] <= st_d[1];
      wsel_q  <= wsel_d;
      rsel_q  <= rsel_d;
      wrow_q  <= wrow_d;
      wcol_q  <= wcol_d;
      rrow_q  <= rrow_d;
      rcol_q  <= rcol_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      dat_q   <= dat_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr)
      mem[waddr] <= bus.i_data;
  end

  assign bus.o_ready = rdy_q;
  assign bus.o_valid = vld_q;
  assign bus.o_sof   = sof_q;
  assign bus.o_eol   = eol_q;
  assign bus.o_data  = dat_q;
  assign bus.o_busy  = (st_q[0] != EMPTY) ||
                       (st_q[1] != EMPTY);
endmodule
